// File: rtl/simon_sequencer.sv
// ---------------------------------------------------------------------------
// simon_sequencer
//
// Game-level controller for the Simon Says datapath. Each round it appends one
// pseudo-random direction to the stored sequence. It then plays the whole
// sequence back as timed highlight requests. Finally it checks the player's
// clicks against the stored sequence.
//
// Ports:
//   clock          system clock
//   reset_n        synchronous, active-low reset
//   start          one-cycle pulse, begins a new game from IDLE, WIN or FAIL
//   btn_valid      one-cycle pulse, player clicked a direction
//   btn_dir        clicked direction (00 up, 01 down, 10 right, 11 left)
//   show_on        highlight request for the show_dir square
//   show_dir       direction to highlight (same encoding as btn_dir)
//   level          current sequence length (0 in IDLE)
//   awaiting_input high while the player is expected to click
//   win            sticky, set on completing a MAX_LEN round
//   fail           sticky, set on a wrong click or an input timeout
//
// Every output is a flop loaded from the next-state values. The outputs
// therefore change on the same edge as the state they describe. A click echo
// appears on the cycle after the accepted click and lasts one cycle.
// ---------------------------------------------------------------------------
module simon_sequencer #(
    parameter int          MAX_LEN       = 16,
    parameter int          LEN_W         = 5,
    parameter int          ON_CYCLES     = 25000000,
    parameter int          OFF_CYCLES    = 12500000,
    parameter int          INPUT_TIMEOUT = 250000000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             btn_valid,
    input  logic [1:0]       btn_dir,
    output logic             show_on,
    output logic [1:0]       show_dir,
    output logic [LEN_W-1:0] level,
    output logic             awaiting_input,
    output logic             win,
    output logic             fail
);

    localparam int               IDX_W   = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [31:0]      T_ON    = 32'(ON_CYCLES);
    localparam logic [31:0]      T_OFF   = 32'(OFF_CYCLES);
    localparam logic [31:0]      T_IN    = 32'(INPUT_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_EXTEND, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_PAUSE, S_WIN, S_FAIL
    } state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] length_reg, length_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic [31:0]      timer_reg, timer_next;
    logic [7:0]       lfsr_reg;
    logic [1:0]       seq_reg [MAX_LEN];
    logic             seq_we;

    logic             show_on_reg, show_on_next;
    logic [1:0]       show_dir_reg, show_dir_next;
    logic             awaiting_reg, awaiting_next;
    logic             win_reg, win_next;
    logic             fail_reg, fail_next;
    logic             echo;

    // The timer holds the cycles left including the current one, so a value of 1
    // marks the final cycle in a state. A value of 0 is also treated as expired.
    logic timer_done;
    logic last_step;
    logic btn_match;

    assign timer_done = (timer_reg <= 32'd1);
    assign last_step  = (idx_reg == length_reg - LEN_ONE);
    assign btn_match  = (btn_dir == seq_reg[idx_reg[IDX_W-1:0]]);

    always_comb begin
        state_next  = state_reg;
        length_next = length_reg;
        idx_next    = idx_reg;
        timer_next  = timer_reg;
        seq_we      = 1'b0;
        echo        = 1'b0;
        win_next    = win_reg;
        fail_next   = fail_reg;

        case (state_reg)
            S_IDLE, S_WIN, S_FAIL: begin
                if (start) begin
                    length_next = '0;
                    win_next    = 1'b0;
                    fail_next   = 1'b0;
                    state_next  = S_EXTEND;
                end
            end
            S_EXTEND: begin
                seq_we      = 1'b1;
                length_next = length_reg + LEN_ONE;
                idx_next    = '0;
                timer_next  = T_ON;
                state_next  = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (timer_done) begin
                    timer_next = T_OFF;
                    state_next = S_SHOW_OFF;
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            S_SHOW_OFF: begin
                if (timer_done) begin
                    if (last_step) begin
                        idx_next   = '0;
                        timer_next = T_IN;
                        state_next = S_INPUT;
                    end else begin
                        idx_next   = idx_reg + LEN_ONE;
                        timer_next = T_ON;
                        state_next = S_SHOW_ON;
                    end
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            S_INPUT: begin
                // A click on the final timeout cycle still counts, so the
                // click is checked before the timer.
                if (btn_valid) begin
                    if (btn_match) begin
                        echo       = 1'b1;
                        timer_next = T_IN;
                        if (last_step) begin
                            if (length_reg == LEN_MAX) begin
                                win_next   = 1'b1;
                                state_next = S_WIN;
                            end else begin
                                timer_next = T_OFF;
                                state_next = S_PAUSE;
                            end
                        end else begin
                            idx_next = idx_reg + LEN_ONE;
                        end
                    end else begin
                        fail_next  = 1'b1;
                        state_next = S_FAIL;
                    end
                end else if (timer_done) begin
                    fail_next  = 1'b1;
                    state_next = S_FAIL;
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            S_PAUSE: begin
                if (timer_done) begin
                    state_next = S_EXTEND;
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output next-values. When EXTEND enters the first SHOW_ON of a game, the
    // step being written this edge is not yet in seq_reg. The LFSR bits are
    // forwarded instead.
    always_comb begin
        show_on_next  = echo || (state_next == S_SHOW_ON);
        show_dir_next = 2'b00;
        if (echo) begin
            show_dir_next = btn_dir;
        end else if (state_next == S_SHOW_ON) begin
            if (seq_we && (idx_next == length_reg)) begin
                show_dir_next = lfsr_reg[1:0];
            end else begin
                show_dir_next = seq_reg[idx_next[IDX_W-1:0]];
            end
        end
        awaiting_next = (state_next == S_INPUT);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            length_reg   <= '0;
            idx_reg      <= '0;
            timer_reg    <= '0;
            lfsr_reg     <= LFSR_SEED;
            show_on_reg  <= 1'b0;
            show_dir_reg <= 2'b00;
            awaiting_reg <= 1'b0;
            win_reg      <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            length_reg   <= length_next;
            idx_reg      <= idx_next;
            timer_reg    <= timer_next;
            // Fibonacci LFSR with taps 8,6,5,4. It free-runs in every state.
            lfsr_reg     <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
            show_on_reg  <= show_on_next;
            show_dir_reg <= show_dir_next;
            awaiting_reg <= awaiting_next;
            win_reg      <= win_next;
            fail_reg     <= fail_next;
        end
    end

    // The sequence store is not reset. Entries at or beyond length are never
    // read, so a reset only has to clear length.
    always_ff @(posedge clock) begin
        if (seq_we) begin
            seq_reg[length_reg[IDX_W-1:0]] <= lfsr_reg[1:0];
        end
    end

    assign show_on        = show_on_reg;
    assign show_dir       = show_dir_reg;
    assign level          = length_reg;
    assign awaiting_input = awaiting_reg;
    assign win            = win_reg;
    assign fail           = fail_reg;

endmodule

// File: tb/tb_simon_sequencer.sv
// ---------------------------------------------------------------------------
// tb_simon_sequencer
//
// Bench for simon_sequencer with MAX_LEN=4, ON=3, OFF=2, TIMEOUT=20.
//
// A table of whole games is replayed in a loop. Each entry selects where a
// game ends (win, wrong click or timeout), the click spacing and whether
// start is pulsed alongside clicks.
//
// The reference model keeps the direction LFSR as a free-running 8-bit
// sequence and the expected steps in a queue. From these the bench derives
// every expected highlight, level and flag.
//
// Random spurious button/start pulses are injected during playback. Random
// click gaps and wrong directions are drawn with $urandom.
// ---------------------------------------------------------------------------
module tb_simon_sequencer;

    localparam int         MAX_LEN = 4;
    localparam int         LEN_W   = 3;
    localparam int         ON_C    = 3;
    localparam int         OFF_C   = 2;
    localparam int         TO_C    = 20;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         IDLE_GAP = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             btn_valid = 1'b0;
    logic [1:0]       btn_dir = 2'b00;
    logic             show_on;
    logic [1:0]       show_dir;
    logic [LEN_W-1:0] level;
    logic             awaiting_input;
    logic             win;
    logic             fail;

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C),
        .INPUT_TIMEOUT(TO_C), .LFSR_SEED(SEED)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .btn_valid(btn_valid),
        .btn_dir(btn_dir), .show_on(show_on), .show_dir(show_dir), .level(level),
        .awaiting_input(awaiting_input), .win(win), .fail(fail)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference LFSR: advances once per clock while out of reset.
    // Feedback is the parity of bits 8,6,5,4 (mask 1011_1000).
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'b1011_1000)};
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge clock) m_lfsr <= (!reset_n) ? SEED : lfsr_step(m_lfsr);

    logic [1:0] exp_seq[$];

    typedef struct {
        string name;
        int    kind;        // 0 play to the end, 1 wrong click, 2 timeout
        int    fail_round;
        int    fail_pos;
        int    gap;         // idle INPUT cycles before each click; -1 random
        bit    with_start;  // pulse start together with each correct click
        bit    exp_win;
        bit    exp_fail;
        int    exp_level;
    } game_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_show_on"}, int'(show_on), 0);
        chk({tag, "_show_dir"}, int'(show_dir), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_awaiting"}, int'(awaiting_input), 0);
        chk({tag, "_win"}, int'(win), 0);
        chk({tag, "_fail"}, int'(fail), 0);
    endtask

    task automatic inject();
        if ($urandom_range(0, 2) == 0) begin
            btn_valid = 1'b1;
            btn_dir   = 2'($urandom);
        end
        if ($urandom_range(0, 4) == 0) start = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        // Now in EXTEND: flags already cleared, new step sampled from the LFSR.
        chk("extend_level", int'(level), 0);
        chk("extend_win", int'(win), 0);
        chk("extend_fail", int'(fail), 0);
        chk("extend_show_on", int'(show_on), 0);
        exp_seq.delete();
        exp_seq.push_back(m_lfsr[1:0]);
    endtask

    task automatic playback(input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < ON_C; c++) begin
                inject();
                tick();
                btn_valid = 1'b0;
                start = 1'b0;
                chk("play_on", int'(show_on), 1);
                chk("play_dir", int'(show_dir), int'(exp_seq[i]));
                chk("play_await", int'(awaiting_input), 0);
            end
            for (int c = 0; c < OFF_C; c++) begin
                inject();
                tick();
                btn_valid = 1'b0;
                start = 1'b0;
                chk("play_off", int'(show_on), 0);
            end
        end
        tick();
        chk("input_await", int'(awaiting_input), 1);
        chk("input_level", int'(level), n);
        chk("input_show_on", int'(show_on), 0);
        $display("round %0d: played %0d highlights", n, n);
    endtask

    task automatic click(input int gap, input logic [1:0] d, input bit with_start);
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("wait_await", int'(awaiting_input), 1);
            chk("wait_fail", int'(fail), 0);
        end
        btn_valid = 1'b1;
        btn_dir   = d;
        start     = with_start;
        tick();
        btn_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Checks after a correct click at position p of round r, and walks
    // through PAUSE into the next EXTEND when the round is complete.
    task automatic after_correct(input int r, input int p, input logic [1:0] d);
        chk("echo_on", int'(show_on), 1);
        chk("echo_dir", int'(show_dir), int'(d));
        if (p < r - 1) begin
            chk("next_await", int'(awaiting_input), 1);
        end else if (r < MAX_LEN) begin
            chk("pause_await", int'(awaiting_input), 0);
            tick();
            chk("pause_off", int'(show_on), 0);
            tick();
            exp_seq.push_back(m_lfsr[1:0]);
        end else begin
            chk("win_set", int'(win), 1);
            chk("win_level", int'(level), MAX_LEN);
            chk("win_await", int'(awaiting_input), 0);
            tick();
            chk("win_show_off", int'(show_on), 0);
        end
    endtask

    task automatic run_game(input game_t g);
        bit done;
        int gap;
        logic [1:0] d;
        done = 1'b0;
        do_start();
        for (int r = 1; r <= MAX_LEN && !done; r++) begin
            playback(r);
            for (int p = 0; p < r && !done; p++) begin
                gap = (g.gap < 0) ? int'($urandom_range(0, TO_C - 1)) : g.gap;
                if (g.kind == 1 && r == g.fail_round && p == g.fail_pos) begin
                    d = exp_seq[p] ^ 2'($urandom_range(1, 3));
                    click(gap, d, 1'b0);
                    chk("wrong_fail", int'(fail), 1);
                    chk("wrong_level", int'(level), r);
                    chk("wrong_show_on", int'(show_on), 0);
                    chk("wrong_await", int'(awaiting_input), 0);
                    $display("round %0d click %0d: wrong dir %0d", r, p, d);
                    done = 1'b1;
                end else if (g.kind == 2 && r == g.fail_round && p == g.fail_pos) begin
                    for (int c = 1; c < TO_C; c++) begin
                        tick();
                        chk("to_await", int'(awaiting_input), 1);
                        chk("to_fail_early", int'(fail), 0);
                    end
                    tick();
                    chk("to_fail", int'(fail), 1);
                    chk("to_await_low", int'(awaiting_input), 0);
                    chk("to_level", int'(level), r);
                    $display("round %0d click %0d: timeout", r, p);
                    done = 1'b1;
                end else begin
                    d = exp_seq[p];
                    click(gap, d, g.with_start);
                    $display("round %0d click %0d: dir %0d gap %0d", r, p, d, gap);
                    after_correct(r, p, d);
                end
            end
        end
        chk({g.name, "_win"}, int'(win), int'(g.exp_win));
        chk({g.name, "_fail"}, int'(fail), int'(g.exp_fail));
        chk({g.name, "_level"}, int'(level), g.exp_level);
        // Clicks after the game has ended must be ignored.
        for (int k = 0; k < 3; k++) begin
            btn_valid = 1'b1;
            btn_dir   = 2'($urandom);
            tick();
            btn_valid = 1'b0;
            chk("end_show_on", int'(show_on), 0);
            chk("end_fail", int'(fail), int'(g.exp_fail));
            chk("end_win", int'(win), int'(g.exp_win));
            chk("end_level", int'(level), g.exp_level);
        end
        $display("game %s: win=%0d fail=%0d level=%0d", g.name, win, fail, level);
    endtask

    task automatic idle_gap();
        for (int k = 0; k < IDLE_GAP; k++) begin
            btn_valid = k[0];
            btn_dir   = 2'($urandom);
            tick();
            btn_valid = 1'b0;
            chk("idle_show_on", int'(show_on), 0);
            chk("idle_await", int'(awaiting_input), 0);
            chk("idle_level", int'(level), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish within 1000000 time units");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        game_t games[6];
        games[0] = '{"full_win",   0, 0, 0,  1, 1'b0, 1'b1, 1'b0, 4};
        games[1] = '{"wrong_r2",   1, 2, 1,  1, 1'b0, 1'b0, 1'b1, 2};
        games[2] = '{"timeout_r1", 2, 1, 0,  0, 1'b0, 1'b0, 1'b1, 1};
        games[3] = '{"late_click", 0, 0, 0, 19, 1'b1, 1'b1, 1'b0, 4};
        games[4] = '{"wrong_r4",   1, 4, 3, -1, 1'b0, 1'b0, 1'b1, 4};
        games[5] = '{"timeout_r3", 2, 3, 2, -1, 1'b0, 1'b0, 1'b1, 3};

        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle_gap();

        foreach (games[i]) run_game(games[i]);

        // Reset in the middle of round 3 playback, then a fresh game.
        do_start();
        for (int r = 1; r <= 2; r++) begin
            playback(r);
            for (int p = 0; p < r; p++) begin
                click(0, exp_seq[p], 1'b0);
                after_correct(r, p, exp_seq[p]);
            end
        end
        tick();
        tick();
        chk("r3_show_on", int'(show_on), 1);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        idle_gap();
        do_start();
        playback(1);
        click(2, exp_seq[0], 1'b0);
        after_correct(1, 0, exp_seq[0]);
        $display("post-reset game: first dir %0d", exp_seq[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
